// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, per-channel
// double-buffered duty compare, boundary-synchronous period/mode update.
module pwm_multi_gen #(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 8,
   localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [WIDTH-1:0]    period,
   input  logic                center,
   input  logic [CHANNELS-1:0] invert,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_ch,
   input  logic [WIDTH-1:0]    wr_duty,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_tick
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] per_q, per_d;
   logic             mode_q, mode_d;
   logic             boundary;

   logic [CHANNELS-1:0][WIDTH-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0][WIDTH-1:0] act_q, act_d;
   logic [CHANNELS-1:0]            pwm_q, pwm_d;
   logic                           tick_q, tick_d;

   // Counter sequencing; a boundary is any cycle whose next count is 0.
   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!ena || per_q == '0) begin
         cnt_d = '0;
         dir_d = 1'b0;
      end else if (!mode_q) begin
         if (cnt_q >= per_q) cnt_d = '0;
         else                cnt_d = cnt_q + ONE;
      end else if (!dir_q) begin
         if (cnt_q >= per_q) begin
            cnt_d = per_q - ONE;
            dir_d = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end else begin
         cnt_d = cnt_q - ONE;
      end
      boundary = (cnt_d == '0);
      if (boundary) dir_d = 1'b0;
   end

   // Shadow transfer at boundaries, with write bypass into the active copy.
   always_comb begin
      per_d  = boundary ? period : per_q;
      mode_d = boundary ? center : mode_q;
      pend_d = pend_q;
      act_d  = act_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (boundary) act_d[ch] = pend_q[ch];
         if (wr_en && wr_ch == CW'(ch)) begin
            pend_d[ch] = wr_duty;
            if (boundary) act_d[ch] = wr_duty;
         end
      end
   end

   // Compare and polarity; disabled outputs rest at the inactive level.
   always_comb begin
      pwm_d  = invert;
      tick_d = ena && (cnt_q == '0);
      if (ena) begin
         for (int ch = 0; ch < CHANNELS; ch++) begin
            pwm_d[ch] = (cnt_q < act_q[ch]) ^ invert[ch];
         end
      end
   end

   // State and output registers, all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         dir_q  <= 1'b0;
         per_q  <= '0;
         mode_q <= 1'b0;
         pend_q <= '0;
         act_q  <= '0;
         pwm_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         per_q  <= per_d;
         mode_q <= mode_d;
         pend_q <= pend_d;
         act_q  <= act_d;
         pwm_q  <= pwm_d;
         tick_q <= tick_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: expected output stream queued from a
// behavioural period model, popped and compared every cycle.
module tb_pwm_multi_gen;

   localparam int CH = 4;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic [W-1:0]  period = '0;
   logic          center = 1'b0;
   logic [CH-1:0] invert = '1;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_ch = '0;
   logic [W-1:0]  wr_duty = '0;
   logic [CH-1:0] pwm_out;
   logic          period_tick;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    dm [CH];
   string phase = "init";

   typedef struct packed {
      logic [CH-1:0] pwm;
      logic          tick;
   } exp_t;

   exp_t sb_q [$];

   always #5 clk = ~clk;

   pwm_multi_gen #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .period      (period),
      .center      (center),
      .invert      (invert),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_duty     (wr_duty),
      .pwm_out     (pwm_out),
      .period_tick (period_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         wr_en = 1'b0;
      end
   endtask

   task automatic wr(input int ch, input int d);
      wr_en   = 1'b1;
      wr_ch   = ch[1:0];
      wr_duty = d[W-1:0];
   endtask

   task automatic cfg_wr(input int ch, input int d);
      wr(ch, d);
      idle(1);
      dm[ch] = d;
   endtask

   function automatic int cnt_at(input int per, input bit ctr, input int j);
      int k;
      if (per == 0) return 0;
      if (!ctr) return j % (per + 1);
      k = j % (2 * per);
      return (k <= per) ? k : 2 * per - k;
   endfunction

   task automatic push_seq(input int per, input bit ctr, input int start,
                           input int n, input logic [CH-1:0] inv);
      exp_t e;
      int   c;
      for (int i = 0; i < n; i++) begin
         c = cnt_at(per, ctr, start + i);
         e.tick = (c == 0);
         for (int ch = 0; ch < CH; ch++) e.pwm[ch] = (c < dm[ch]) ^ inv[ch];
         sb_q.push_back(e);
      end
   endtask

   task automatic push_const(input logic [CH-1:0] inv, input int n);
      exp_t e;
      e.pwm  = inv;
      e.tick = 1'b0;
      repeat (n) sb_q.push_back(e);
   endtask

   task automatic run(input int n);
      exp_t e;
      repeat (n) begin
         step();
         wr_en = 1'b0;
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("pwm", 32'(pwm_out), 32'(e.pwm));
            chk("tick", 32'(period_tick), 32'(e.tick));
         end
      end
   endtask

   initial begin
      for (int ch = 0; ch < CH; ch++) dm[ch] = 0;

      phase = "reset";
      #1;
      chk("pwm", 32'(pwm_out), 32'h0);
      chk("tick", 32'(period_tick), 32'h0);
      step();
      step();
      chk("pwm_hold", 32'(pwm_out), 32'h0);
      rst_n  = 1'b1;
      ena    = 1'b1;
      period = '0;
      step();
      step();
      chk("pwm_rel", 32'(pwm_out), 32'hF);
      chk("tick_p0", 32'(period_tick), 32'h1);
      step();
      chk("tick_p0b", 32'(period_tick), 32'h1);

      phase  = "edge";
      ena    = 1'b0;
      period = 8'd3;
      center = 1'b0;
      invert = '0;
      idle(1);
      cfg_wr(0, 2);
      cfg_wr(1, 0);
      cfg_wr(2, 4);
      cfg_wr(3, 1);
      ena = 1'b1;
      push_seq(3, 1'b0, 0, 12, 4'h0);
      run(12);

      phase  = "centre";
      ena    = 1'b0;
      period = 8'd4;
      center = 1'b1;
      idle(1);
      cfg_wr(0, 2);
      ena = 1'b1;
      push_seq(4, 1'b1, 0, 16, 4'h0);
      run(16);

      phase  = "shadow";
      ena    = 1'b0;
      period = 8'd7;
      center = 1'b0;
      idle(1);
      cfg_wr(0, 3);
      ena = 1'b1;
      push_seq(7, 1'b0, 0, 8, 4'h0);
      dm[0] = 6;
      push_seq(7, 1'b0, 0, 8, 4'h0);
      run(2);
      wr(0, 6);
      run(14);
      push_seq(7, 1'b0, 0, 8, 4'h0);
      dm[0] = 2;
      push_seq(7, 1'b0, 0, 8, 4'h0);
      run(7);
      wr(0, 2);
      run(9);

      phase = "modechg";
      push_seq(7, 1'b0, 0, 8, 4'h0);
      push_seq(2, 1'b1, 0, 8, 4'h0);
      run(3);
      center = 1'b1;
      period = 8'd2;
      run(13);

      phase  = "enable";
      ena    = 1'b0;
      period = 8'd7;
      center = 1'b0;
      invert = 4'hA;
      idle(2);
      cfg_wr(0, 7);
      ena = 1'b1;
      push_seq(7, 1'b0, 0, 5, 4'hA);
      run(5);
      ena = 1'b0;
      push_const(4'hA, 2);
      run(2);
      ena = 1'b1;
      push_seq(7, 1'b0, 0, 3, 4'hA);
      run(3);
      invert = 4'h8;
      push_seq(7, 1'b0, 3, 5, 4'h8);
      run(5);

      phase  = "midreset";
      invert = 4'hF;
      push_seq(7, 1'b0, 0, 3, 4'hF);
      run(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("pwm_async", 32'(pwm_out), 32'h0);
      chk("tick_async", 32'(period_tick), 32'h0);
      step();
      rst_n  = 1'b1;
      ena    = 1'b1;
      period = '0;
      step();
      step();
      chk("pwm_rel", 32'(pwm_out), 32'hF);
      chk("tick_p0", 32'(period_tick), 32'h1);

      phase  = "cleared";
      ena    = 1'b0;
      period = 8'd3;
      invert = '0;
      idle(1);
      for (int ch = 0; ch < CH; ch++) dm[ch] = 0;
      ena = 1'b1;
      push_seq(3, 1'b0, 0, 4, 4'h0);
      run(4);

      phase = "end";
      chk("sb_left", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Multi-channel PWM generator, the parametrised successor of the single-channel 4-bit PWM block. One shared period counter drives `CHANNELS` compare outputs. Each output has its own double-buffered duty register and an output-polarity control. A run-time period register and an edge-aligned or centre-aligned counting mode are applied glitch-free at period boundaries. The block sits between the register/IO front end (`ui_in`/`uio_in` decode) and the `uo_out` pins.

## Interface
- `CHANNELS`, default 4: number of PWM outputs (1..8).
- `WIDTH`, default 8: counter, period and duty width in bits (2..16).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  run enable. Low holds the counter at 0.
- `period`  in  `WIDTH`  requested terminal count, sampled at the boundary.
- `center`  in  1  requested mode, sampled at the boundary. 0 = edge-aligned, 1 = centre-aligned.
- `invert`  in  `CHANNELS`  per-channel polarity. Applied live, not shadowed.
- `wr_en`  in  1  duty write strobe.
- `wr_ch`  in  `clog2(CHANNELS)` (min 1)  channel to write. Writes to out-of-range channels are ignored.
- `wr_duty`  in  `WIDTH`  duty value to write.
- `pwm_out`  out  `CHANNELS`  registered PWM outputs.
- `period_tick`  out  1  registered one-cycle strobe marking the first cycle of each period.

## Operation
- **State:**
  - `cnt` (`WIDTH`)
  - `dir` (0 = up)
  - `per_s`, `mode_s` (active copies of `period`/`center`)
  - `pend[ch]` and `act[ch]` (`WIDTH` each)
- **Edge mode:** `cnt` runs 0,1,..,`per_s`,0,… Period length is `per_s`+1 cycles.
- **Centre mode:** `cnt` runs 0 up to `per_s`, then `per_s`-1 down to 1, then 0. Period length is 2·`per_s` cycles. `dir` flips when `cnt`==`per_s` going up, and returns to up when the next value is 0.
- **`per_s`==0, either mode:** `cnt` stays 0 and every cycle is a boundary.
- **Boundary cycle:** the cycle whose next `cnt` is 0.
  - On its closing edge: `per_s`←`period`, `mode_s`←`center`, `act[ch]`←`pend[ch]` for all ch, and `dir`←up.
  - A mode change therefore always restarts cleanly from 0.
- **Duty writes:**
  - `wr_en` writes `pend[wr_ch]`←`wr_duty` every cycle.
  - A write in a boundary cycle bypasses into `act[wr_ch]` on the same edge.
  - Mid-period writes never affect the current period.
- **Compare:** `raw[ch]` = (`cnt` < `act[ch]`), unsigned, `WIDTH`-bit.
  - `act`==0 gives constant low.
  - `act` > `per_s` gives constant high.
  - In edge mode at `per_s`=2^`WIDTH`-1, the maximum on-time is 2^`WIDTH`-1 of 2^`WIDTH` cycles.
- **Output:** `pwm_out[ch]`←`raw[ch]` XOR `invert[ch]`.
- **`ena` low:**
  - `cnt`←0 and `dir`←up.
  - `pwm_out[ch]`←`invert[ch]` (inactive level) and `period_tick`←0.
  - Every cycle is treated as a boundary, so shadow transfer is continuous and configuration is live on enable.
- **`ena` rising:** the first enabled cycle has `cnt`=0, which starts a fresh period.
- **`period` reduced mid-period:** no effect until the boundary. The counter never skips past `per_s`.

## Timing
- **Reset** (asynchronous assert, synchronous release by the `clk` domain). All of the following clear to 0:
  - `cnt`, `dir`, `per_s`, `mode_s`
  - all `pend`, all `act`
  - `pwm_out`, `period_tick`
- **Reset mid-operation:** outputs drop to 0 immediately, without waiting for `clk`.
- **Latency:**
  - `pwm_out` in cycle t+1 reflects `cnt`, `act` and `invert` of cycle t.
  - `period_tick` in cycle t+1 = (`ena` and `cnt`==0 in cycle t), so it is co-cycle with the first output sample of each period.
  - In edge mode with `per_s`=0, `period_tick` stays high continuously.
- **Write-to-output latency:**
  - A mid-period write appears on `pwm_out` 1 cycle after the first `cnt`=0 of the next period.
  - A write in a boundary cycle appears 2 cycles after the write.
- **Handshake:** none. `wr_en` is accepted every cycle with no back-pressure.
- **Simultaneous writes:** two writes to the same channel in consecutive cycles keep the last one.

## Test plan
- **Reset:** assert `rst_n`=0 mid-period with `invert`=all 1 -> `pwm_out`=0 and `period_tick`=0 immediately. After release with `ena`=1 and `period`=0, `pwm_out`=`invert` within 2 cycles.
- **Edge mode:** `period`=3, `center`=0, ch0 duty 2, ch1 duty 0, ch2 duty 4 -> ch0 pattern 1,1,0,0 repeating; ch1 constant 0; ch2 constant 1; `period_tick` every 4th cycle, aligned with the first 1 of ch0.
- **Centre mode:** `period`=4, `center`=1, ch0 duty 2 -> `cnt` sequence 0,1,2,3,4,3,2,1; ch0 pattern 1,1,0,0,0,0,0,1; `period_tick` every 8 cycles.
- **Shadowing:** in edge mode with `period`=7, write ch0 duty 6 at `cnt`=2 while `act`=3 -> the current period still shows 3 high cycles, the next period shows 6. Repeat the write in a boundary cycle -> the next period shows the new value.
- **Mode/period change:** switch `center` 0->1 and `period` 7->2 mid-period -> the old period completes, then `cnt` runs 0,1,2,1 with no glitch pulse.
- **Enable/invert:** drop `ena` at `cnt`=5 -> `pwm_out`=`invert` next cycle. Toggle `invert[1]` while running -> ch1 flips 1 cycle later. Re-raise `ena` -> the period restarts at `cnt`=0.
